rr_switch_allocator_4port: RTL and testbench

- Round-robin, wormhole-locking switch allocator for the 4-port mesh router (X1, X2, Y, LOCAL).
- Sits between the route-compute stage and the crossbar output registers.
- Each cycle it takes one destination request per input and grants at most one input per output, honouring downstream full.
- Emits per-output crossbar select codes and per-input advance grants.
- Once a multi-flit packet wins an output, that output stays locked to the packet's input until the tail flit passes.

---
 rtl/rr_switch_allocator_4port_if.sv | 39 +++
 rtl/rr_switch_allocator_4port.sv | 208 ++++++++++++++++++++
 tb/tb_rr_switch_allocator_4port.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/rr_switch_allocator_4port_if.sv
// -----------------------------------------------------------------------------
// rr_switch_allocator_4port_if
// Bundle of request/response signals between the route-compute stage, the
// switch allocator and the crossbar of the 4-port mesh router.
// Port index / code map: 0=X1, 1=X2, 2=Y, 3=LOCAL; codes 0=STOP, 1..4 = port+1.
//   req_valid[3:0]    per-input request valid
//   req_tail[3:0]     per-input: requesting flit is the packet tail
//   req_dst_*[2:0]    per-input requested output code
//   out_full[3:0]     per-output downstream full
//   grant[3:0]        per-input advance pulse (registered)
//   out_*_sw[2:0]     per-output crossbar select code (registered)
//   lock_busy[3:0]    per-output wormhole lock indicator (registered)
// master: requester/crossbar side; slave: allocator side.
// -----------------------------------------------------------------------------
interface rr_switch_allocator_4port_if;
    logic [3:0] req_valid;
    logic [3:0] req_tail;
    logic [2:0] req_dst_x1;
    logic [2:0] req_dst_x2;
    logic [2:0] req_dst_y;
    logic [2:0] req_dst_local;
    logic [3:0] out_full;
    logic [3:0] grant;
    logic [2:0] out_x1_sw;
    logic [2:0] out_x2_sw;
    logic [2:0] out_y_sw;
    logic [2:0] out_local_sw;
    logic [3:0] lock_busy;

    modport master (
        output req_valid, req_tail, req_dst_x1, req_dst_x2, req_dst_y, req_dst_local, out_full,
        input  grant, out_x1_sw, out_x2_sw, out_y_sw, out_local_sw, lock_busy
    );

    modport slave (
        input  req_valid, req_tail, req_dst_x1, req_dst_x2, req_dst_y, req_dst_local, out_full,
        output grant, out_x1_sw, out_x2_sw, out_y_sw, out_local_sw, lock_busy
    );
endinterface

// File: rtl/rr_switch_allocator_4port.sv
// -----------------------------------------------------------------------------
// rr_switch_allocator_4port
// Round-robin, wormhole-locking switch allocator for a 4-port mesh router.
// Each output runs a small IDLE/LOCKED FSM with its own round-robin pointer.
// A winning non-tail flit locks the output to its input until the tail passes.
// All outputs are registered: a request present at a clock edge produces
// grant/sw right after that edge, for exactly one cycle per flit.
// Ports:
//   clk    clock
//   rst_n  asynchronous active-low reset
//   en     allocator enable (low: no grants, all state frozen)
//   bus    slave side of rr_switch_allocator_4port_if
// -----------------------------------------------------------------------------
module rr_switch_allocator_4port #(
    parameter int NUM_PORTS = 4,
    parameter int CODE_W    = 3
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         en,
    rr_switch_allocator_4port_if.slave   bus
);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } out_state_t;

    localparam logic [CODE_W-1:0] CODE_STOP = 3'd0;

    // Request decode
    logic [CODE_W-1:0] dst_s      [NUM_PORTS];
    logic [3:0]        dst_ok_s;
    logic [1:0]        dst_idx_s  [NUM_PORTS];
    logic [3:0]        blocked_s;
    logic [3:0]        req_mask_s [NUM_PORTS];

    // FSM state and next state
    out_state_t        state_r     [NUM_PORTS];
    out_state_t        state_nxt_s [NUM_PORTS];
    logic [1:0]        ptr_r       [NUM_PORTS];
    logic [1:0]        ptr_nxt_s   [NUM_PORTS];
    logic [1:0]        owner_r     [NUM_PORTS];
    logic [1:0]        owner_nxt_s [NUM_PORTS];

    // Per-output grant vectors and select codes for this cycle
    logic [3:0]        win_s       [NUM_PORTS];
    logic [CODE_W-1:0] sw_nxt_s    [NUM_PORTS];
    logic [3:0]        grant_s;

    // Registered outputs
    logic [3:0]        grant_r;
    logic [CODE_W-1:0] sw_r        [NUM_PORTS];
    logic [3:0]        lock_busy_r;

    assign dst_s[0] = bus.req_dst_x1;
    assign dst_s[1] = bus.req_dst_x2;
    assign dst_s[2] = bus.req_dst_y;
    assign dst_s[3] = bus.req_dst_local;

    // Decode destination codes; 0 and 5..7 are treated as no request
    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            case (dst_s[i])
                3'd1:    begin dst_ok_s[i] = 1'b1; dst_idx_s[i] = 2'd0; end
                3'd2:    begin dst_ok_s[i] = 1'b1; dst_idx_s[i] = 2'd1; end
                3'd3:    begin dst_ok_s[i] = 1'b1; dst_idx_s[i] = 2'd2; end
                3'd4:    begin dst_ok_s[i] = 1'b1; dst_idx_s[i] = 2'd3; end
                default: begin dst_ok_s[i] = 1'b0; dst_idx_s[i] = 2'd0; end
            endcase
        end
    end

    // An owner asking for some other output than the one it holds is ignored everywhere
    always_comb begin
        blocked_s = 4'b0000;
        for (int o = 0; o < NUM_PORTS; o++) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if ((state_r[o] == ST_LOCKED) && (owner_r[o] == 2'(i)) &&
                    !(dst_ok_s[i] && (dst_idx_s[i] == 2'(o)))) begin
                    blocked_s[i] = 1'b1;
                end else begin
                    blocked_s[i] = blocked_s[i];
                end
            end
        end
    end

    // Per-output eligible request masks
    always_comb begin
        for (int o = 0; o < NUM_PORTS; o++) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                req_mask_s[o][i] = bus.req_valid[i] && dst_ok_s[i] &&
                                   (dst_idx_s[i] == 2'(o)) && !blocked_s[i];
            end
        end
    end

    // Per-output FSM next state, round-robin search and grant generation
    always_comb begin
        logic       found_v;
        logic [1:0] win_v;
        logic [1:0] cand_v;
        found_v = 1'b0;
        win_v   = 2'd0;
        cand_v  = 2'd0;
        grant_s = 4'b0000;
        for (int o = 0; o < NUM_PORTS; o++) begin
            state_nxt_s[o] = state_r[o];
            ptr_nxt_s[o]   = ptr_r[o];
            owner_nxt_s[o] = owner_r[o];
            win_s[o]       = 4'b0000;
            sw_nxt_s[o]    = CODE_STOP;
            if (!en) begin
                state_nxt_s[o] = state_r[o];
            end else begin
                case (state_r[o])
                    ST_IDLE: begin
                        if (!bus.out_full[o] && (req_mask_s[o] != 4'b0000)) begin
                            found_v = 1'b0;
                            win_v   = 2'd0;
                            for (int k = 0; k < NUM_PORTS; k++) begin
                                cand_v = ptr_r[o] + 2'(k);
                                if (!found_v && req_mask_s[o][cand_v]) begin
                                    found_v = 1'b1;
                                    win_v   = cand_v;
                                end else begin
                                    found_v = found_v;
                                end
                            end
                            win_s[o][win_v] = 1'b1;
                            sw_nxt_s[o]     = {1'b0, win_v} + 3'd1;
                            if (bus.req_tail[win_v]) begin
                                ptr_nxt_s[o] = win_v + 2'd1;
                            end else begin
                                // Pointer stays put while locked; it advances past the owner at the tail
                                state_nxt_s[o] = ST_LOCKED;
                                owner_nxt_s[o] = win_v;
                            end
                        end else begin
                            state_nxt_s[o] = ST_IDLE;
                        end
                    end
                    ST_LOCKED: begin
                        if (!bus.out_full[o] && req_mask_s[o][owner_r[o]]) begin
                            win_s[o][owner_r[o]] = 1'b1;
                            sw_nxt_s[o]          = {1'b0, owner_r[o]} + 3'd1;
                            if (bus.req_tail[owner_r[o]]) begin
                                state_nxt_s[o] = ST_IDLE;
                                ptr_nxt_s[o]   = owner_r[o] + 2'd1;
                            end else begin
                                state_nxt_s[o] = ST_LOCKED;
                            end
                        end else begin
                            state_nxt_s[o] = ST_LOCKED;
                        end
                    end
                    default: begin
                        state_nxt_s[o] = ST_IDLE;
                    end
                endcase
            end
            grant_s = grant_s | win_s[o];
        end
    end

    // FSM state, round-robin pointers and lock owners
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int o = 0; o < NUM_PORTS; o++) begin
                state_r[o] <= ST_IDLE;
                ptr_r[o]   <= 2'd0;
                owner_r[o] <= 2'd0;
            end
        end else begin
            for (int o = 0; o < NUM_PORTS; o++) begin
                state_r[o] <= state_nxt_s[o];
                ptr_r[o]   <= ptr_nxt_s[o];
                owner_r[o] <= owner_nxt_s[o];
            end
        end
    end

    // Output registers: grant, crossbar selects and lock indicators
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_r     <= 4'b0000;
            lock_busy_r <= 4'b0000;
            for (int o = 0; o < NUM_PORTS; o++) begin
                sw_r[o] <= CODE_STOP;
            end
        end else begin
            grant_r <= grant_s;
            for (int o = 0; o < NUM_PORTS; o++) begin
                sw_r[o]        <= sw_nxt_s[o];
                lock_busy_r[o] <= (state_nxt_s[o] == ST_LOCKED);
            end
        end
    end

    assign bus.grant        = grant_r;
    assign bus.out_x1_sw    = sw_r[0];
    assign bus.out_x2_sw    = sw_r[1];
    assign bus.out_y_sw     = sw_r[2];
    assign bus.out_local_sw = sw_r[3];
    assign bus.lock_busy    = lock_busy_r;

endmodule

// File: tb/tb_rr_switch_allocator_4port.sv
// -----------------------------------------------------------------------------
// tb_rr_switch_allocator_4port
// Directed, table-driven bench for rr_switch_allocator_4port. Destination and
// select vectors are written as 12-bit octal literals whose digits read
// {LOCAL, Y, X2, X1} for selects and {in3, in2, in1, in0} for destinations.
// -----------------------------------------------------------------------------
module tb_rr_switch_allocator_4port;

    logic clk = 1'b0;
    logic rst_n;
    logic en;

    always #5 clk = ~clk;

    rr_switch_allocator_4port_if bus ();

    rr_switch_allocator_4port dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .bus   (bus)
    );

    typedef struct packed {
        logic        en;
        logic [3:0]  valid;
        logic [3:0]  tail;
        logic [11:0] dst;
        logic [3:0]  full;
        logic [3:0]  exp_grant;
        logic [11:0] exp_sw;
        logic [3:0]  exp_lb;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    task automatic add(input logic e, input logic [3:0] v, input logic [3:0] t,
                       input logic [11:0] d, input logic [3:0] f,
                       input logic [3:0] g, input logic [11:0] sw, input logic [3:0] lb);
        vec_t r;
        r.en = e; r.valid = v; r.tail = t; r.dst = d; r.full = f;
        r.exp_grant = g; r.exp_sw = sw; r.exp_lb = lb;
        vecs.push_back(r);
    endtask

    task automatic drive(input logic e, input logic [3:0] v, input logic [3:0] t,
                         input logic [11:0] d, input logic [3:0] f);
        en                = e;
        bus.req_valid     = v;
        bus.req_tail      = t;
        bus.req_dst_x1    = d[2:0];
        bus.req_dst_x2    = d[5:3];
        bus.req_dst_y     = d[8:6];
        bus.req_dst_local = d[11:9];
        bus.out_full      = f;
    endtask

    task automatic expect_out(input string name, input logic [3:0] g,
                              input logic [11:0] sw, input logic [3:0] lb);
        logic [11:0] act_sw;
        act_sw = {bus.out_local_sw, bus.out_y_sw, bus.out_x2_sw, bus.out_x1_sw};
        checks++;
        if (bus.grant !== g || act_sw !== sw || bus.lock_busy !== lb) begin
            errors++;
            $display("FAIL %s: got grant=%b sw=%o lock_busy=%b, expected grant=%b sw=%o lock_busy=%b",
                     name, bus.grant, act_sw, bus.lock_busy, g, sw, lb);
        end
    endtask

    // Drive, clock once, sample one time unit after the edge
    task automatic cycle(input string name, input logic e, input logic [3:0] v,
                         input logic [3:0] t, input logic [11:0] d, input logic [3:0] f,
                         input logic [3:0] g, input logic [11:0] sw, input logic [3:0] lb);
        drive(e, v, t, d, f);
        @(posedge clk);
        #1;
        expect_out(name, g, sw, lb);
    endtask

    initial begin
        // en, valid, tail, dst, full  ->  grant, sw, lock_busy
        add(1'b1, 4'b0000, 4'b0000, 12'o0000, 4'b0000, 4'b0000, 12'o0000, 4'b0000); // idle
        add(1'b1, 4'b0001, 4'b0001, 12'o0003, 4'b0000, 4'b0001, 12'o0100, 4'b0000); // X1 -> Y
        add(1'b1, 4'b0000, 4'b0000, 12'o0000, 4'b0000, 4'b0000, 12'o0000, 4'b0000); // one cycle only
        add(1'b1, 4'b1111, 4'b1111, 12'o4444, 4'b0000, 4'b0001, 12'o1000, 4'b0000); // RR on LOCAL
        add(1'b1, 4'b1111, 4'b1111, 12'o4444, 4'b0000, 4'b0010, 12'o2000, 4'b0000);
        add(1'b1, 4'b1111, 4'b1111, 12'o4444, 4'b0000, 4'b0100, 12'o3000, 4'b0000);
        add(1'b1, 4'b1111, 4'b1111, 12'o4444, 4'b0000, 4'b1000, 12'o4000, 4'b0000);
        add(1'b1, 4'b1111, 4'b1111, 12'o4444, 4'b0000, 4'b0001, 12'o1000, 4'b0000);
        add(1'b1, 4'b0001, 4'b0001, 12'o0006, 4'b0000, 4'b0000, 12'o0000, 4'b0000); // dst=6
        add(1'b1, 4'b0001, 4'b0001, 12'o0006, 4'b0000, 4'b0000, 12'o0000, 4'b0000);
        add(1'b1, 4'b1111, 4'b1111, 12'o4444, 4'b0000, 4'b0010, 12'o2000, 4'b0000); // ptr untouched
        add(1'b0, 4'b1111, 4'b1111, 12'o4444, 4'b0000, 4'b0000, 12'o0000, 4'b0000); // en=0
        add(1'b0, 4'b1111, 4'b1111, 12'o4444, 4'b0000, 4'b0000, 12'o0000, 4'b0000);
        add(1'b1, 4'b1111, 4'b1111, 12'o4444, 4'b0000, 4'b0100, 12'o3000, 4'b0000); // RR resumes
        add(1'b1, 4'b0100, 4'b0100, 12'o0300, 4'b0100, 4'b0000, 12'o0000, 4'b0000); // Y full
        add(1'b1, 4'b0100, 4'b0100, 12'o0300, 4'b0100, 4'b0000, 12'o0000, 4'b0000);
        add(1'b1, 4'b0100, 4'b0100, 12'o0300, 4'b0100, 4'b0000, 12'o0000, 4'b0000);
        add(1'b1, 4'b0100, 4'b0100, 12'o0300, 4'b0000, 4'b0100, 12'o0300, 4'b0000); // full cleared
        add(1'b1, 4'b1111, 4'b1111, 12'o3412, 4'b0000, 4'b1111, 12'o3412, 4'b0000); // all outputs
        add(1'b1, 4'b0000, 4'b0000, 12'o0000, 4'b0000, 4'b0000, 12'o0000, 4'b0000);

        drive(1'b1, 4'b0000, 4'b0000, 12'o0000, 4'b0000);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        expect_out("reset_state", 4'b0000, 12'o0000, 4'b0000);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            cycle($sformatf("vec%0d", i), vecs[i].en, vecs[i].valid, vecs[i].tail,
                  vecs[i].dst, vecs[i].full, vecs[i].exp_grant, vecs[i].exp_sw, vecs[i].exp_lb);
        end

        // Reset in the middle of a lock on X1 (LOCAL pointer is at 3 here)
        cycle("pre_reset", 1'b1, 4'b1001, 4'b1000, 12'o4001, 4'b0000, 4'b1001, 12'o4001, 4'b0001);
        #2;
        rst_n = 1'b0;
        #1;
        expect_out("reset_mid_lock", 4'b0000, 12'o0000, 4'b0000);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycle("post_reset_ptr0", 1'b1, 4'b1001, 4'b1001, 12'o4004, 4'b0000, 4'b0001, 12'o1000, 4'b0000);
        cycle("post_reset_next", 1'b1, 4'b1000, 4'b1000, 12'o4004, 4'b0000, 4'b1000, 12'o4000, 4'b0000);

        // Wormhole: X2 sends a 4-flit packet to X1 while LOCAL also wants X1
        for (int k = 0; k < 4; k++) begin
            cycle($sformatf("worm_flit%0d", k + 1), 1'b1, 4'b1010,
                  (k == 3) ? 4'b1010 : 4'b1000, 12'o1010, 4'b0000,
                  4'b0010, 12'o0002, (k == 3) ? 4'b0000 : 4'b0001);
        end
        cycle("worm_next_pkt", 1'b1, 4'b1000, 4'b1000, 12'o1000, 4'b0000, 4'b1000, 12'o0004, 4'b0000);

        // Lock on Y stalled by full, owner protocol violation, then tail
        cycle("lock_y_head", 1'b1, 4'b0001, 4'b0000, 12'o0003, 4'b0000, 4'b0001, 12'o0100, 4'b0100);
        cycle("lock_y_full", 1'b1, 4'b0001, 4'b0000, 12'o0003, 4'b0100, 4'b0000, 12'o0000, 4'b0100);
        cycle("lock_violation", 1'b1, 4'b0111, 4'b0110, 12'o0322, 4'b0000, 4'b0010, 12'o0020, 4'b0100);
        cycle("lock_y_tail", 1'b1, 4'b0101, 4'b0101, 12'o0303, 4'b0000, 4'b0001, 12'o0100, 4'b0000);
        cycle("y_after_tail", 1'b1, 4'b0100, 4'b0100, 12'o0300, 4'b0000, 4'b0100, 12'o0300, 4'b0000);

        drive(1'b1, 4'b0000, 4'b0000, 12'o0000, 4'b0000);
        @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
